// File: rtl/am_query_scheduler.sv
// am_query_scheduler: round-robin arbiter and fold/prototype sequencer for a shared AM distance datapath
module am_query_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int REQ_ID_WIDTH    = 2,
    parameter int NUM_FOLDS       = 10,
    parameter int NUM_FOLDS_WIDTH = 4,
    parameter int NUM_PAIRS       = 2,
    parameter int PROTO_WIDTH     = 2,
    parameter int DIST_WIDTH      = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       hv_load,
    output logic [REQ_ID_WIDTH-1:0]    sel_id,
    output logic [NUM_FOLDS_WIDTH-1:0] fold_idx,
    output logic [PROTO_WIDTH-1:0]     proto_idx,
    output logic                       dp_active,
    input  logic [DIST_WIDTH-1:0]      dist_in,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [REQ_ID_WIDTH-1:0]    res_id,
    output logic [NUM_PAIRS-1:0]       res_label
);
    localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD  = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
    localparam logic [PROTO_WIDTH-1:0]     LAST_PROTO = PROTO_WIDTH'(2 * NUM_PAIRS - 1);
    localparam logic [REQ_ID_WIDTH-1:0]    LAST_REQ   = REQ_ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [REQ_ID_WIDTH-1:0] rr_ptr;
    logic [REQ_ID_WIDTH-1:0] sel_reg;
    logic [REQ_ID_WIDTH-1:0] win_id;
    logic                    any_valid;
    logic                    fire;
    logic                    last_fold;
    logic [DIST_WIDTH-1:0]   dp;
    logic [DIST_WIDTH-1:0]   dn;
    logic [DIST_WIDTH-1:0]   acc_p;
    logic [DIST_WIDTH-1:0]   acc_n;
    logic [DIST_WIDTH:0]     dn_total;
    logic                    pair_ge;

    // Scan downward so the requester closest above rr_ptr is the last one to overwrite win_id
    always_comb begin
        int j;
        j = 0;
        win_id = '0;
        any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = (int'(rr_ptr) + i) % NUM_REQ;
            if (req_valid[REQ_ID_WIDTH'(j)]) begin
                win_id = REQ_ID_WIDTH'(j);
                any_valid = 1'b1;
            end
        end
    end

    assign fire      = (state == IDLE) && any_valid;
    assign req_ready = fire ? (NUM_REQ'(1) << win_id) : '0;
    assign hv_load   = fire;
    assign sel_id    = fire ? win_id : sel_reg;
    assign dp_active = state == RUN;
    assign res_valid = state == DONE;
    assign res_id    = sel_reg;
    assign last_fold = fold_idx == LAST_FOLD;
    assign acc_p     = (fold_idx == '0) ? dist_in : dp + dist_in;
    assign acc_n     = (fold_idx == '0) ? dist_in : dn + dist_in;
    // Compare one bit wider so the final negative fold cannot wrap the sum
    assign dn_total  = {1'b0, dn} + {1'b0, dist_in};
    assign pair_ge   = {1'b0, dp} >= dn_total;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            sel_reg   <= '0;
            fold_idx  <= '0;
            proto_idx <= '0;
            res_label <= '0;
            dp        <= '0;
            dn        <= '0;
        end else begin
            case (state)
                IDLE: if (fire) begin
                    state     <= RUN;
                    sel_reg   <= win_id;
                    rr_ptr    <= (win_id == LAST_REQ) ? '0 : win_id + REQ_ID_WIDTH'(1);
                    fold_idx  <= '0;
                    proto_idx <= '0;
                end
                RUN: begin
                    if (proto_idx[0]) dn <= acc_n;
                    else dp <= acc_p;
                    if (proto_idx[0] && last_fold) res_label[proto_idx[PROTO_WIDTH-1:1]] <= pair_ge;
                    fold_idx <= last_fold ? '0 : fold_idx + NUM_FOLDS_WIDTH'(1);
                    if (last_fold) proto_idx <= (proto_idx == LAST_PROTO) ? '0 : proto_idx + PROTO_WIDTH'(1);
                    if (last_fold && proto_idx == LAST_PROTO) state <= DONE;
                end
                DONE: if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_am_query_scheduler.sv
// tb_am_query_scheduler: directed plus randomized queries checked against a per-query summing model
module tb_am_query_scheduler;
    localparam int NR = 4;
    localparam int NF = 10;
    localparam int NPROTO = 4;
    localparam int RUN_LEN = NF * NPROTO;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic        hv_load;
    logic [1:0]  sel_id;
    logic [3:0]  fold_idx;
    logic [1:0]  proto_idx;
    logic        dp_active;
    logic [10:0] dist_in;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [1:0]  res_label;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int rr = 0;
    int fire_cycle = 0;
    int prev_fire = 0;

    am_query_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .hv_load(hv_load), .sel_id(sel_id), .fold_idx(fold_idx), .proto_idx(proto_idx),
        .dp_active(dp_active), .dist_in(dist_in), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_label(res_label)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v);
        for (int i = 0; i < NR; i++) if (v[(rr + i) % NR]) return (rr + i) % NR;
        return 0;
    endfunction

    task automatic check_reset_outputs();
        check("rst_req_ready", req_ready, 0);
        check("rst_hv_load", hv_load, 0);
        check("rst_sel_id", sel_id, 0);
        check("rst_fold", fold_idx, 0);
        check("rst_proto", proto_idx, 0);
        check("rst_dp_active", dp_active, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_label", res_label, 0);
    endtask

    // mode 0: small random (ties likely), 1: 5 even/3 odd, 2: pair0 3/5 pair1 4/4, 3: large random
    function automatic int dist_for(input int mode, input int k);
        int p;
        p = k / NF;
        if (mode == 1) return (p % 2 == 0) ? 5 : 3;
        if (mode == 2) return (p == 0) ? 3 : (p == 1) ? 5 : 4;
        if (mode == 3) return int'($urandom_range(150, 204));
        return int'($urandom_range(0, 3));
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after the result is accepted
    task automatic query(input logic [3:0] v, input int mode, input bit drop, input int hold,
                         input bit rdy_run, input int exp_label);
        int id;
        int sum[NPROTO];
        int d;
        logic [1:0] lab;
        foreach (sum[p]) sum[p] = 0;
        req_valid = v;
        res_ready = 1'b0;
        #1;
        id = pick(v);
        check("grant", req_ready, 32'(1) << id);
        check("hv_load_fire", hv_load, 1);
        check("sel_id_fire", sel_id, id);
        rr = (id + 1) % NR;
        prev_fire = fire_cycle;
        fire_cycle = cycle;
        for (int k = 0; k < RUN_LEN; k++) begin
            @(negedge clk);
            if (drop) req_valid = '0;
            res_ready = rdy_run;
            d = dist_for(mode, k);
            dist_in = 11'(d);
            sum[k / NF] += d;
            #1;
            check("fold_idx", fold_idx, k % NF);
            check("proto_idx", proto_idx, k / NF);
            check("dp_active", dp_active, 1);
            check("run_req_ready", req_ready, 0);
            check("run_res_valid", res_valid, 0);
            check("run_sel_id", sel_id, id);
        end
        @(negedge clk);
        res_ready = (hold == 0);
        dist_in = '0;
        #1;
        lab = {sum[2] >= sum[3], sum[0] >= sum[1]};
        if (exp_label >= 0) check("label_directed", lab, exp_label);
        check("latency", cycle - fire_cycle, RUN_LEN + 1);
        check("res_valid", res_valid, 1);
        check("res_id", res_id, id);
        check("res_label", res_label, lab);
        check("done_dp_active", dp_active, 0);
        check("done_fold", fold_idx, 0);
        check("done_proto", proto_idx, 0);
        check("done_req_ready", req_ready, 0);
        check("done_hv_load", hv_load, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check("hold_res_valid", res_valid, 1);
            check("hold_res_id", res_id, id);
            check("hold_res_label", res_label, lab);
            check("hold_req_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        dist_in = '0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        @(negedge clk);

        query(4'b0100, 1, 1'b0, 0, 1'b0, 2'b11);
        query(4'b1000, 2, 1'b0, 0, 1'b0, 2'b10);

        for (int q = 0; q < 5; q++) begin
            query(4'b1111, 0, 1'b0, 0, 1'b1, -1);
            if (q > 0) check("rr_spacing", fire_cycle - prev_fire, RUN_LEN + 2);
        end

        query(4'b1111, 3, 1'b0, 20, 1'b0, -1);
        query(4'b0100, 3, 1'b1, 0, 1'b1, -1);

        // Reset mid-query: fold 4 of proto 1 for requester 1
        req_valid = 4'b0010;
        #1;
        check("rst_grant", req_ready, 4'b0010);
        @(negedge clk);
        for (int k = 0; k < NF + 4; k++) begin
            dist_in = 11'($urandom_range(0, 7));
            @(negedge clk);
        end
        #1;
        check("pre_rst_fold", fold_idx, 4);
        check("pre_rst_proto", proto_idx, 1);
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;
        rr = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            check("no_result_after_rst", res_valid, 0);
        end
        query(4'b0101, 0, 1'b0, 0, 1'b0, -1);

        for (int q = 0; q < 4; q++) begin
            query(4'($urandom_range(1, 15)), ($urandom_range(0, 1) == 0) ? 0 : 3, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
